// File: rtl/io_bus_arbiter.sv
// CPU/DMA arbiter for the io_controller register port: DMA-first priority with a CPU
// anti-starvation limit, a BUSY timeout guard and rejection of simultaneous read+write.
module io_bus_arbiter #(
  parameter int DATA_W        = 32,
  parameter int TIMEOUT_CYC   = 64,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_wen,
  input  logic              cpu_ren,
  input  logic [3:0]        cpu_be,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_err,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data_i,
  input  logic              dma_wen,
  input  logic              dma_ren,
  input  logic [3:0]        dma_be,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_data_o,
  output logic              dma_err,
  output logic [DATA_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_data_i,
  output logic              io_wen,
  output logic              io_ren,
  output logic [3:0]        io_be,
  input  logic              io_ack,
  input  logic [DATA_W-1:0] io_data_o
);

  localparam int CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int STREAK_W = $clog2(DMA_BURST_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DMA_BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                wen_q, wen_d, ren_q, ren_d;
  logic                sel_cpu_q, sel_cpu_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_data_q, cpu_data_d, dma_data_q, dma_data_d;
  logic                cpu_err_q, cpu_err_d, dma_err_q, dma_err_d;

  logic                cpu_pend, dma_pend, win_cpu;
  logic                resp_load, resp_err;
  logic [DATA_W-1:0]   resp_data;

  assign cpu_pend = cpu_wen | cpu_ren;
  assign dma_pend = dma_wen | dma_ren;
  assign win_cpu  = cpu_pend && (!dma_pend || streak_q == STREAK_MAX);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wen_d      = wen_q;
    ren_d      = ren_q;
    sel_cpu_d  = sel_cpu_q;
    streak_d   = streak_q;
    cnt_d      = cnt_q;
    cpu_data_d = cpu_data_q;
    cpu_err_d  = cpu_err_q;
    dma_data_d = dma_data_q;
    dma_err_d  = dma_err_q;
    resp_load  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cpu_pend || dma_pend) begin
          sel_cpu_d = win_cpu;
          addr_d    = win_cpu ? cpu_addr   : dma_addr;
          wdata_d   = win_cpu ? cpu_data_i : dma_data_i;
          be_d      = win_cpu ? cpu_be     : dma_be;
          wen_d     = win_cpu ? cpu_wen    : dma_wen;
          ren_d     = win_cpu ? cpu_ren    : dma_ren;
          // Only DMA grants that make the CPU wait extend the streak.
          if (!win_cpu && cpu_pend)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
          else
            streak_d = '0;
          if (wen_d && ren_d) begin
            resp_load = 1'b1;
            resp_err  = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (io_ack) begin
          resp_load = 1'b1;
          resp_data = ren_q ? io_data_o : '0;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_load = 1'b1;
          resp_err  = 1'b1;
          resp_data = '1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Only the winner's response registers change; the other side keeps its last value.
    if (resp_load) begin
      if (sel_cpu_d) begin
        cpu_data_d = resp_data;
        cpu_err_d  = resp_err;
      end else begin
        dma_data_d = resp_data;
        dma_err_d  = resp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      sel_cpu_q  <= 1'b0;
      streak_q   <= '0;
      cnt_q      <= '0;
      cpu_data_q <= '0;
      cpu_err_q  <= 1'b0;
      dma_data_q <= '0;
      dma_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      sel_cpu_q  <= sel_cpu_d;
      streak_q   <= streak_d;
      cnt_q      <= cnt_d;
      cpu_data_q <= cpu_data_d;
      cpu_err_q  <= cpu_err_d;
      dma_data_q <= dma_data_d;
      dma_err_q  <= dma_err_d;
    end
  end

  assign io_addr    = addr_q;
  assign io_data_i  = wdata_q;
  assign io_be      = be_q;
  assign io_wen     = (state_q == S_BUSY) && wen_q;
  assign io_ren     = (state_q == S_BUSY) && ren_q;
  assign cpu_ack    = (state_q == S_RESP) && sel_cpu_q;
  assign dma_ack    = (state_q == S_RESP) && !sel_cpu_q;
  assign cpu_data_o = cpu_data_q;
  assign cpu_err    = cpu_err_q;
  assign dma_data_o = dma_data_q;
  assign dma_err    = dma_err_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: single accesses, arbitration order, timeout,
// illegal requests and reset abort, with a programmable-latency io_controller responder.
module tb_io_bus_arbiter;
  localparam int DW  = 32;
  localparam int TO  = 64;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cpu_addr, cpu_data_i, dma_addr, dma_data_i;
  logic          cpu_wen, cpu_ren, dma_wen, dma_ren;
  logic [3:0]    cpu_be, dma_be;
  logic          cpu_ack, cpu_err, dma_ack, dma_err;
  logic [DW-1:0] cpu_data_o, dma_data_o;
  logic [DW-1:0] io_addr, io_data_i, io_data_o;
  logic          io_wen, io_ren, io_ack;
  logic [3:0]    io_be;

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_delay    = 0;
  int strobe_cnt   = 0;

  io_bus_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO), .DMA_BURST_MAX(MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_data_o(cpu_data_o), .cpu_err(cpu_err),
    .dma_addr(dma_addr), .dma_data_i(dma_data_i), .dma_wen(dma_wen), .dma_ren(dma_ren),
    .dma_be(dma_be), .dma_ack(dma_ack), .dma_data_o(dma_data_o), .dma_err(dma_err),
    .io_addr(io_addr), .io_data_i(io_data_i), .io_wen(io_wen), .io_ren(io_ren),
    .io_be(io_be), .io_ack(io_ack), .io_data_o(io_data_o)
  );

  always #5 clk = ~clk;

  // io_controller model: acks on the ack_delay-th strobe cycle (0 = never).
  always @(negedge clk) begin
    if (io_wen || io_ren) begin
      strobe_cnt = strobe_cnt + 1;
      io_ack = (ack_delay != 0) && (strobe_cnt == ack_delay);
    end else begin
      strobe_cnt = 0;
      io_ack = 1'b0;
    end
  end

  // Advances clock edges until an ack is seen (bounded), counting strobe cycles on the way.
  task automatic wait_ack(output int edges, output logic got_cpu, output logic got_dma,
                          output int wen_cyc, output int ren_cyc);
    edges = 0; got_cpu = 1'b0; got_dma = 1'b0; wen_cyc = 0; ren_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      edges++;
      if (io_wen) wen_cyc++;
      if (io_ren) ren_cyc++;
      if (cpu_ack || dma_ack) begin
        got_cpu = cpu_ack;
        got_dma = dma_ack;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({cpu_ack, dma_ack, cpu_err, dma_err, io_wen, io_ren} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags got=%b exp=000000", {cpu_ack, dma_ack, cpu_err, dma_err, io_wen, io_ren});
    end
    tests_run++;
    if ({io_addr, io_data_i, io_be} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_io_bus got=%h/%h/%b exp=0", io_addr, io_data_i, io_be);
    end
    tests_run++;
    if ({cpu_data_o, dma_data_o} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data_o got=%h/%h exp=0", cpu_data_o, dma_data_o);
    end
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_cpu_write();
    int edges, wc, rc;
    logic gc, gd;
    ack_delay = 2; io_data_o = 32'hDEAD_BEEF;
    cpu_addr = 32'h1F80_1108; cpu_data_i = 32'h80; cpu_be = 4'b0011; cpu_wen = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({io_wen, io_ren, io_addr, io_data_i, io_be} !== {1'b1, 1'b0, 32'h1F80_1108, 32'h80, 4'b0011}) begin
      tests_failed++;
      $display("[TB] FAIL cpu_wr_strobe got=%b%b %h %h %b exp=10 1f801108 00000080 0011",
               io_wen, io_ren, io_addr, io_data_i, io_be);
    end
    wait_ack(edges, gc, gd, wc, rc);
    tests_run++;
    if ({gc, gd} !== 2'b10 || edges !== 2) begin
      tests_failed++;
      $display("[TB] FAIL cpu_wr_ack got=cpu%b dma%b at+%0d exp=cpu1 dma0 at+2", gc, gd, edges);
    end
    tests_run++;
    if (wc + 1 !== 2) begin
      tests_failed++;
      $display("[TB] FAIL cpu_wr_wen_cycles got=%0d exp=2", wc + 1);
    end
    tests_run++;
    if (cpu_err !== 1'b0 || cpu_data_o !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL cpu_wr_resp got=err%b data%h exp=err0 data00000000", cpu_err, cpu_data_o);
    end
    $display("[TB] cpu write 1f801108 ack after %0d cycles err=%b", edges + 1, cpu_err);
    cpu_wen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dma_read();
    int edges, wc, rc;
    logic gc, gd;
    ack_delay = 1; io_data_o = 32'h0000_0123;
    dma_addr = 32'h1F80_1100; dma_be = 4'b1111; dma_ren = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({io_ren, io_wen, io_addr} !== {2'b10, 32'h1F80_1100}) begin
      tests_failed++;
      $display("[TB] FAIL dma_rd_strobe got=%b%b %h exp=10 1f801100", io_ren, io_wen, io_addr);
    end
    wait_ack(edges, gc, gd, wc, rc);
    tests_run++;
    if ({gc, gd} !== 2'b01 || edges !== 1) begin
      tests_failed++;
      $display("[TB] FAIL dma_rd_ack got=cpu%b dma%b at+%0d exp=cpu0 dma1 at+1", gc, gd, edges);
    end
    tests_run++;
    if (dma_data_o !== 32'h123 || dma_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dma_rd_resp got=%h err%b exp=00000123 err0", dma_data_o, dma_err);
    end
    $display("[TB] dma read 1f801100 data=%h", dma_data_o);
    dma_ren = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    int edges, wc, rc;
    logic gc, gd;
    logic [9:0] exp_cpu;
    exp_cpu = 10'b10000_10000;  // bit i set: grant i goes to CPU (D,D,D,D,C repeating)
    ack_delay = 1; io_data_o = 32'h5;
    cpu_addr = 32'h1F80_1110; cpu_ren = 1'b1;
    dma_addr = 32'h1F80_1120; dma_ren = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_ack(edges, gc, gd, wc, rc);
      tests_run++;
      if ({gc, gd} !== (exp_cpu[i] ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("[TB] FAIL grant_order[%0d] got=cpu%b dma%b exp=%s", i, gc, gd, exp_cpu[i] ? "C" : "D");
      end
      $display("[TB] grant %0d -> %s", i, gc ? "C" : (gd ? "D" : "-"));
    end
    cpu_ren = 1'b0; dma_ren = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int edges, wc, rc;
    logic gc, gd;
    ack_delay = 0;
    cpu_addr = 32'h1F80_1104; cpu_ren = 1'b1;
    wait_ack(edges, gc, gd, wc, rc);
    tests_run++;
    if (gc !== 1'b1 || edges !== TO + 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_latency got=cpu%b at+%0d exp=cpu1 at+%0d", gc, edges, TO + 1);
    end
    tests_run++;
    if (rc !== TO) begin
      tests_failed++;
      $display("[TB] FAIL timeout_ren_cycles got=%0d exp=%0d", rc, TO);
    end
    tests_run++;
    if (cpu_data_o !== 32'hFFFF_FFFF || cpu_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_resp got=%h err%b exp=ffffffff err1", cpu_data_o, cpu_err);
    end
    $display("[TB] cpu read timeout ack after %0d cycles", edges);
    cpu_ren = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int edges, wc, rc;
    logic gc, gd;
    ack_delay = 2;
    cpu_addr = 32'h1F80_1114; cpu_wen = 1'b1; cpu_ren = 1'b1;
    wait_ack(edges, gc, gd, wc, rc);
    tests_run++;
    if (gc !== 1'b1 || edges !== 1) begin
      tests_failed++;
      $display("[TB] FAIL illegal_latency got=cpu%b at+%0d exp=cpu1 at+1", gc, edges);
    end
    tests_run++;
    if (wc !== 0 || rc !== 0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_strobes got=wen%0d ren%0d exp=0 0", wc, rc);
    end
    tests_run++;
    if (cpu_err !== 1'b1 || cpu_data_o !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_resp got=%h err%b exp=00000000 err1", cpu_data_o, cpu_err);
    end
    $display("[TB] cpu illegal wen+ren rejected err=%b", cpu_err);
    cpu_wen = 1'b0; cpu_ren = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int edges, wc, rc;
    logic gc, gd;
    ack_delay = 0;
    cpu_addr = 32'h1F80_1118; cpu_data_i = 32'h77; cpu_be = 4'b1111; cpu_wen = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (io_wen !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_pre_busy got=io_wen%b exp=1", io_wen);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({io_wen, io_ren, cpu_ack, dma_ack} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_after_rst got=%b exp=0000", {io_wen, io_ren, cpu_ack, dma_ack});
    end
    rst = 1'b0;
    ack_delay = 2;
    wait_ack(edges, gc, gd, wc, rc);
    tests_run++;
    if (gc !== 1'b1 || edges !== 3 || wc !== 2 || cpu_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_next_req got=cpu%b at+%0d wen%0d err%b exp=cpu1 at+3 wen2 err0",
               gc, edges, wc, cpu_err);
    end
    $display("[TB] reset abort then cpu write ack after %0d cycles", edges);
    cpu_wen = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; io_data_o = '0;
    cpu_addr = '0; cpu_data_i = '0; cpu_wen = 1'b0; cpu_ren = 1'b0; cpu_be = '0;
    dma_addr = '0; dma_data_i = '0; dma_wen = 1'b0; dma_ren = 1'b0; dma_be = '0;
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_priority();
    test_timeout();
    test_illegal();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
